// File: rtl/regfile_ctrl.sv
// Sequencing controller between a host command port and a 3-port register file.
// Handles single-cycle writes, two-cycle reads with a held response, and zero sweeps.
module regfile_ctrl #(
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr_a,
  input  logic [4:0]  cmd_addr_b,
  input  logic [31:0] cmd_wdata,
  input  logic        clear_req,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_a,
  output logic [31:0] rsp_data_b,
  output logic        busy,
  output logic        rf_we3,
  output logic [4:0]  rf_a1,
  output logic [4:0]  rf_a2,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2
);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, RESP} stateT;

  stateT      state;
  logic       idleReady;
  logic       clearPending;
  logic [4:0] sweepCnt;

  // A same-cycle clear request wins over a command, so it masks readiness directly.
  assign cmd_ready = idleReady & ~clear_req;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      rf_we3       <= 1'b0;
      rf_a1        <= 5'd0;
      rf_a2        <= 5'd0;
      rf_a3        <= 5'd0;
      rf_wd3       <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_data_a   <= 32'd0;
      rsp_data_b   <= 32'd0;
      idleReady    <= 1'b0;
      clearPending <= 1'b0;
      sweepCnt     <= 5'd1;
    end else begin
      rf_we3 <= 1'b0;
      if (clear_req && state != CLEAR) begin
        clearPending <= 1'b1;
      end
      case (state)
        CLEAR: begin
          if (rf_we3 && rf_a3 == 5'd31) begin
            state     <= IDLE;
            idleReady <= 1'b1;
          end else begin
            rf_we3   <= 1'b1;
            rf_a3    <= sweepCnt;
            rf_wd3   <= 32'd0;
            sweepCnt <= sweepCnt + 5'd1;
          end
        end
        IDLE: begin
          // Entering a sweep writes address 1 straight away so it lasts 31 cycles.
          if (clearPending || clear_req) begin
            state        <= CLEAR;
            clearPending <= 1'b0;
            idleReady    <= 1'b0;
            rf_we3       <= 1'b1;
            rf_a3        <= 5'd1;
            rf_wd3       <= 32'd0;
            sweepCnt     <= 5'd2;
          end else if (cmd_valid && idleReady) begin
            idleReady <= 1'b0;
            if (cmd_write) begin
              state  <= WRITE;
              rf_we3 <= 1'b1;
              rf_a3  <= cmd_addr_a;
              rf_wd3 <= cmd_wdata;
            end else begin
              state <= READ;
              rf_a1 <= cmd_addr_a;
              rf_a2 <= cmd_addr_b;
            end
          end else begin
            idleReady <= 1'b1;
          end
        end
        WRITE: begin
          state     <= IDLE;
          idleReady <= ~(clearPending | clear_req);
        end
        READ: begin
          rsp_data_a <= rf_rd1;
          rsp_data_b <= rf_rd2;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            idleReady <= ~(clearPending | clear_req);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: table vectors, directed corner cases and
// randomized traffic checked against a plain array model of register contents.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr_a, cmd_addr_b;
  logic [31:0] cmd_wdata;
  logic        clear_req;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic        busy;
  logic        rf_we3;
  logic [4:0]  rf_a1, rf_a2, rf_a3;
  logic [31:0] rf_wd3, rf_rd1, rf_rd2;

  int assertCount = 0;
  int failCount = 0;

  regfile_ctrl #(.CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
    .clear_req(clear_req),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .busy(busy),
    .rf_we3(rf_we3), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3),
    .rf_wd3(rf_wd3), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  always #5 clk = ~clk;

  // Register file attached to the controller; register 0 always reads zero.
  logic [31:0] rfMem [32];
  always @(posedge clk) begin
    if (rf_we3 && rf_a3 != 5'd0) rfMem[rf_a3] <= rf_wd3;
  end
  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : rfMem[rf_a1];
  assign rf_rd2 = (rf_a2 == 5'd0) ? 32'd0 : rfMem[rf_a2];

  // Expected register contents as seen by the host.
  logic [31:0] refMem [32];

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] data;
    logic [31:0] expA;
    logic [31:0] expB;
  } vecT;

  vecT         vecs [11];
  bit          ok, found;
  logic [31:0] ra, rb;
  logic [4:0]  ta, tb;
  logic [31:0] td;
  int          op;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 1; i < 32; i++) refMem[i] = 32'd0;
  endtask

  // Present a command at a negedge and return at the negedge after it is accepted.
  task automatic applyStimulus(input bit wr, input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] wd, output bit accepted);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = wd;
    accepted = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      checkOutput("cmd accept timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy && cmd_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) checkOutput("idle timeout", 64'd0, 64'd1);
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input bit clr);
    bit acc;
    applyStimulus(1'b1, a, 5'd0, d, acc);
    if (!acc) return;
    checkOutput("write port", {rf_we3, rf_a3, rf_wd3}, {1'b1, a, d});
    if (a != 5'd0) refMem[a] = d;
    clear_req = clr;
    @(negedge clk);
    clear_req = 1'b0;
    checkOutput("write single cycle", {rf_we3, busy, cmd_ready}, {1'b0, 1'b0, ~clr});
    if (clr) begin
      clearModel();
      waitIdle();
    end
  endtask

  task automatic doRead(input logic [4:0] a, input logic [4:0] b, input int hold,
                        output logic [31:0] da, output logic [31:0] db);
    bit acc;
    applyStimulus(1'b0, a, b, 32'd0, acc);
    da = 32'hx; db = 32'hx;
    if (!acc) return;
    checkOutput("read addr regs", {rf_a1, rf_a2, rf_we3, rsp_valid}, {a, b, 2'b00});
    @(negedge clk);
    // Accept cycle, READ cycle, then the response is visible.
    checkOutput("read latency", {rsp_valid, cmd_ready, rf_we3}, 3'b100);
    da = rsp_data_a; db = rsp_data_b;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("resp hold flags", {rsp_valid, cmd_ready, busy, rf_we3}, 4'b1010);
      checkOutput("resp hold data", {rsp_data_a, rsp_data_b}, {da, db});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("resp release", {rsp_valid, busy, cmd_ready}, 3'b001);
    checkOutput("resp retain", {rsp_data_a, rsp_data_b}, {da, db});
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  5'd0,  32'hdeadbeef, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd1,  5'd0,  32'h0,        32'hdeadbeef, 32'h0};
    vecs[2]  = '{1'b1, 5'd10, 5'd0,  32'hbeefdead, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd10, 5'd1,  32'h0,        32'hbeefdead, 32'hdeadbeef};
    vecs[4]  = '{1'b1, 5'd0,  5'd0,  32'h12345678, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd0,  5'd10, 32'h0,        32'h0,        32'hbeefdead};
    vecs[6]  = '{1'b1, 5'd31, 5'd0,  32'ha5a5a5a5, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd31, 5'd31, 32'h0,        32'ha5a5a5a5, 32'ha5a5a5a5};
    vecs[8]  = '{1'b0, 5'd2,  5'd1,  32'h0,        32'h0,        32'hdeadbeef};
    vecs[9]  = '{1'b1, 5'd1,  5'd0,  32'h00000001, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 5'd1,  5'd31, 32'h0,        32'h00000001, 32'ha5a5a5a5};

    for (int i = 0; i < 32; i++) refMem[i] = 32'd0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr_a = 5'd0; cmd_addr_b = 5'd0;
    cmd_wdata = 32'd0; clear_req = 1'b0; rsp_ready = 1'b0;

    // Reset state and the power-up sweep.
    @(negedge clk);
    checkOutput("reset flags", {rf_we3, rsp_valid, cmd_ready, busy}, 4'b0001);
    checkOutput("reset addr/data", {rf_a1, rf_a2, rf_a3, rf_wd3}, 47'd0);
    checkOutput("reset rsp data", {rsp_data_a, rsp_data_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      checkOutput($sformatf("sweep step %0d", k), {busy, rf_we3, cmd_ready, rf_a3, rf_wd3},
                  {1'b1, 1'b1, 1'b0, 5'(k), 32'd0});
    end
    @(negedge clk);
    checkOutput("sweep done", {busy, rf_we3, cmd_ready}, 3'b001);

    // Table-driven writes and reads, each read back-to-back after the preceding write.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) begin
        doWrite(vecs[i].a, vecs[i].data, 1'b0);
      end else begin
        doRead(vecs[i].a, vecs[i].b, 0, ra, rb);
        checkOutput($sformatf("vec %0d data a", i), ra, vecs[i].expA);
        checkOutput($sformatf("vec %0d data b", i), rb, vecs[i].expB);
      end
    end

    // Response held off for five cycles.
    doRead(5'd10, 5'd31, 5, ra, rb);
    checkOutput("held read", {ra, rb}, {32'hbeefdead, 32'ha5a5a5a5});

    // Clear request beats a simultaneous command.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr_a = 5'd5; cmd_wdata = 32'h55;
    clear_req = 1'b1;
    #1;
    checkOutput("clear masks ready", cmd_ready, 1'b0);
    @(negedge clk);
    clear_req = 1'b0;
    checkOutput("clear first write", {busy, rf_we3, cmd_ready, rf_a3, rf_wd3}, {3'b110, 5'd1, 32'd0});
    clearModel();
    doWrite(5'd5, 32'h55, 1'b0);
    doRead(5'd1, 5'd5, 0, ra, rb);
    checkOutput("after clear", {ra, rb}, {32'd0, 32'h55});

    // Randomized traffic against the array model.
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 9));
      ta = 5'($urandom_range(0, 31));
      tb = 5'($urandom_range(0, 31));
      td = $urandom;
      if (op < 4) begin
        doWrite(ta, td, 1'b0);
      end else if (op < 8) begin
        doRead(ta, tb, int'($urandom_range(0, 3)), ra, rb);
        checkOutput("rand read a", ra, refMem[ta]);
        checkOutput("rand read b", rb, refMem[tb]);
      end else if (op == 8) begin
        doWrite(ta, td, 1'b1);
      end else begin
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        checkOutput("rand clear start", {busy, rf_we3, rf_a3}, {2'b11, 5'd1});
        clearModel();
        waitIdle();
      end
    end

    // Reset in the middle of a sweep restarts it from address 1.
    doWrite(5'd20, 32'h1234abcd, 1'b0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (rf_we3 && rf_a3 == 5'd15) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach sweep 15", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset flags", {rf_we3, rsp_valid, cmd_ready, busy}, 4'b0001);
    checkOutput("async reset addr/data", {rf_a1, rf_a2, rf_a3, rf_wd3}, 47'd0);
    checkOutput("async reset rsp data", {rsp_data_a, rsp_data_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("sweep restart", {busy, rf_we3, rf_a3}, {2'b11, 5'd1});
    clearModel();
    waitIdle();
    doRead(5'd20, 5'd15, 0, ra, rb);
    checkOutput("after sweep reset", {ra, rb}, 64'd0);

    // Reset while a response is pending drops it.
    doWrite(5'd7, 32'hcafef00d, 1'b0);
    applyStimulus(1'b0, 5'd7, 5'd7, 32'd0, ok);
    @(negedge clk);
    checkOutput("resp before reset", {rsp_valid, rsp_data_a}, {1'b1, 32'hcafef00d});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("resp dropped", {rsp_valid, cmd_ready, rsp_data_a, rsp_data_b}, 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    @(negedge clk);
    waitIdle();
    doRead(5'd7, 5'd0, 0, ra, rb);
    checkOutput("after resp reset", {ra, rb}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1, meaning: 1 = zero-sweep of registers 1..31 after reset release; 0 = enter IDLE directly.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  controller accepts command this cycle.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr_a  input  5  write address (write) / read port-1 address (read).
REQ-008 cmd_addr_b  input  5  read port-2 address (read only).
REQ-009 cmd_wdata  input  32  write data.
REQ-010 clear_req  input  1  single-cycle request to zero registers 1..31.
REQ-011 rsp_valid  output  1  read response available.
REQ-012 rsp_ready  input  1  host consumes response.
REQ-013 rsp_data_a / rsp_data_b  output  32 each  captured port-1 / port-2 read data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 rf_we3  output  1; rf_a1, rf_a2, rf_a3  output  5 each; rf_wd3  output  32; all registered, driving the register file write-enable, read and write ports.
REQ-016 rf_rd1, rf_rd2  input  32 each  combinational register file read data (register 0 reads 0).

Function
REQ-017 States: CLEAR, IDLE, WRITE, READ, RESP; encoding is an implementation choice.
REQ-018 cmd_ready = 1 only in IDLE with no pending clear; a command is accepted on a rising edge with cmd_valid & cmd_ready.
REQ-019 Accepted write: next state WRITE; for exactly one cycle rf_we3=1, rf_a3=cmd_addr_a, rf_wd3=cmd_wdata; then IDLE. No response is generated.
REQ-020 Write to address 0 is issued normally; the register file discards it.
REQ-021 Accepted read: next state READ with rf_a1=cmd_addr_a, rf_a2=cmd_addr_b registered; at the following edge, rf_rd1/rf_rd2 are captured into rsp_data_a/rsp_data_b, rsp_valid rises, and the state becomes RESP.
REQ-022 Read latency: rsp_valid high exactly 2 cycles after the accepting edge.
REQ-023 RESP: rsp_valid and rsp_data hold stable until an edge with rsp_ready=1; then rsp_valid=0 and state IDLE; cmd_ready stays 0 throughout RESP.
REQ-024 A read issued in the cycle after a write completes returns the newly written data (write commits before read capture).
REQ-025 CLEAR: sweep counter 1..31; each cycle rf_we3=1, rf_a3=counter, rf_wd3=0; after address 31, rf_we3=0 and state IDLE; duration 31 cycles.
REQ-026 clear_req sampled high in any state sets a pending flag; the pending flag forces IDLE -> CLEAR in preference to a simultaneous cmd_valid, which is not accepted that cycle.
REQ-027 clear_req during CLEAR is ignored (no restart, no extra pass).
REQ-028 rf_we3 is 0 in IDLE, READ, and RESP.
REQ-029 rsp_data_a/b retain their last captured values when rsp_valid=0.

Reset
REQ-030 rst_n low asynchronously forces: rf_we3=0; rf_a1/a2/a3=0; rf_wd3=0; rsp_valid=0; rsp_data_a/b=0; cmd_ready=0; pending clear=0; sweep counter=1.
REQ-031 While reset is asserted, state is CLEAR if CLEAR_ON_RESET=1, else IDLE; busy follows the state.
REQ-032 Reset asserted mid-sweep, mid-read, or in RESP aborts the operation; any pending response is lost; after release, behaviour restarts per REQ-031.

Verification
REQ-033 Reset release, CLEAR_ON_RESET=1 -> busy high 31 cycles, rf_a3 steps 1..31 with rf_wd3=0; then cmd_ready=1.
REQ-034 Write 0xdeadbeef to addr 1, then read a=1, b=0 -> rsp_data_a=0xdeadbeef, rsp_data_b=0, rsp_valid 2 cycles after the read accept.
REQ-035 Write 0xbeefdead to addr 10 with an immediately following read a=10 -> rsp_data_a=0xbeefdead.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, cmd_ready=0; pulse rsp_ready -> IDLE next cycle.
REQ-037 clear_req coincident with cmd_valid in IDLE -> command not accepted, CLEAR runs, then the command is accepted; reading the previously written address 1 returns 0.
REQ-038 rst_n pulsed low at sweep address 15 -> outputs zero immediately, sweep restarts at address 1.
